// File: rtl/single_port_ram_arbiter_pkg.sv
// Shared helpers for the single-port RAM arbiter slice.
package single_port_ram_arbiter_pkg;

    // Ceiling log2, used to size the word address from the memory depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port word memory: one access per cycle, registered read data.
// All words and the read register clear asynchronously on resetn low.
module single_port_ram #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [WIDTH-1:0]         write_data,
    output logic [WIDTH-1:0]         read_data
);

    logic [WIDTH-1:0] memory [DEPTH];

    // Memory array and read register; read data only changes on a read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            memory    <= '{default: '0};
            read_data <= '0;
        end else begin
            if (write_enable) begin
                memory[address] <= write_data;
            end
            if (read_enable) begin
                read_data <= memory[address];
            end
        end
    end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM.
// Build option: SINGLE_PORT_RAM_ARBITER_ROUND_ROBIN_EN selects a priority
// pointer that alternates after every grant; otherwise requester 0 always
// wins on contention and no pointer register exists.
module single_port_ram_arbiter
    import single_port_ram_arbiter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     request0_valid,
    output logic                     request0_ready,
    input  logic                     request0_write,
    input  logic [ADDRESS_WIDTH-1:0] request0_address,
    input  logic [WIDTH-1:0]         request0_write_data,
    output logic                     response0_valid,
    output logic [WIDTH-1:0]         response0_data,
    input  logic                     request1_valid,
    output logic                     request1_ready,
    input  logic                     request1_write,
    input  logic [ADDRESS_WIDTH-1:0] request1_address,
    input  logic [WIDTH-1:0]         request1_write_data,
    output logic                     response1_valid,
    output logic [WIDTH-1:0]         response1_data
);

    localparam logic REQUESTER_0 = 1'b0;
    localparam logic REQUESTER_1 = 1'b1;

    logic                     favoured;
    logic                     winner;
    logic                     grant0;
    logic                     grant1;
    logic                     read_enable;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] access_address;
    logic [WIDTH-1:0]         access_write_data;
    logic [WIDTH-1:0]         read_data;
    logic [WIDTH-1:0]         held0_data;
    logic [WIDTH-1:0]         held1_data;

`ifdef SINGLE_PORT_RAM_ARBITER_ROUND_ROBIN_EN
    logic pointer;

    // Priority pointer: after any grant the other requester becomes favoured.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pointer <= REQUESTER_0;
        end else if (grant0) begin
            pointer <= REQUESTER_1;
        end else if (grant1) begin
            pointer <= REQUESTER_0;
        end
    end

    assign favoured = pointer;
`else
    assign favoured = REQUESTER_0;
`endif

    // Arbitration: favoured requester wins contention, lone requester always wins.
    always_comb begin
        winner = REQUESTER_0;
        if (request0_valid && request1_valid) begin
            winner = favoured;
        end else if (request1_valid) begin
            winner = REQUESTER_1;
        end
        grant0 = resetn && request0_valid && (winner == REQUESTER_0);
        grant1 = resetn && request1_valid && (winner == REQUESTER_1);
    end

    assign request0_ready = grant0;
    assign request1_ready = grant1;

    // Route the granted transaction to the single memory port.
    always_comb begin
        access_address    = grant1 ? request1_address    : request0_address;
        access_write_data = grant1 ? request1_write_data : request0_write_data;
        read_enable       = (grant0 && !request0_write) || (grant1 && !request1_write);
        write_enable      = (grant0 &&  request0_write) || (grant1 &&  request1_write);
    end

    single_port_ram #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) memory (
        .clock        (clock),
        .resetn       (resetn),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (access_address),
        .write_data   (access_write_data),
        .read_data    (read_data)
    );

    // Response strobes one cycle after an accepted read; held copies keep each
    // requester's last word since the shared read register is overwritten by
    // the other requester's reads.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            response0_valid <= 1'b0;
            response1_valid <= 1'b0;
            held0_data      <= '0;
            held1_data      <= '0;
        end else begin
            response0_valid <= grant0 && !request0_write;
            response1_valid <= grant1 && !request1_write;
            if (response0_valid) begin
                held0_data <= read_data;
            end
            if (response1_valid) begin
                held1_data <= read_data;
            end
        end
    end

    // Present fresh read data during the response cycle, held data otherwise.
    always_comb begin
        response0_data = response0_valid ? read_data : held0_data;
        response1_data = response1_valid ? read_data : held1_data;
    end

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Self-checking bench for single_port_ram_arbiter; expectations follow the
// SINGLE_PORT_RAM_ARBITER_ROUND_ROBIN_EN setting of the build.
module tb_single_port_ram_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef SINGLE_PORT_RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             request0_valid = 1'b0, request1_valid = 1'b0;
    logic             request0_write = 1'b0, request1_write = 1'b0;
    logic [AW-1:0]    request0_address = '0, request1_address = '0;
    logic [WIDTH-1:0] request0_write_data = '0, request1_write_data = '0;
    logic             request0_ready, request1_ready;
    logic             response0_valid, response1_valid;
    logic [WIDTH-1:0] response0_data, response1_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] model_mem [DEPTH];
    int               model_favoured;
    bit               exp_valid [2];
    logic [WIDTH-1:0] exp_data  [2];

    single_port_ram_arbiter #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .request0_valid      (request0_valid),
        .request0_ready      (request0_ready),
        .request0_write      (request0_write),
        .request0_address    (request0_address),
        .request0_write_data (request0_write_data),
        .response0_valid     (response0_valid),
        .response0_data      (response0_data),
        .request1_valid      (request1_valid),
        .request1_ready      (request1_ready),
        .request1_write      (request1_write),
        .request1_address    (request1_address),
        .request1_write_data (request1_write_data),
        .response1_valid     (response1_valid),
        .response1_data      (response1_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_favoured = 0;
        exp_valid[0] = 1'b0;
        exp_valid[1] = 1'b0;
        exp_data[0]  = '0;
        exp_data[1]  = '0;
    endtask

    task automatic check_responses();
        check("response0_valid", 32'(response0_valid), 32'(exp_valid[0]));
        check("response0_data",  32'(response0_data),  32'(exp_data[0]));
        check("response1_valid", 32'(response1_valid), 32'(exp_valid[1]));
        check("response1_data",  32'(response1_data),  32'(exp_data[1]));
    endtask

    // Reset with both requesters presenting reads: nothing may be accepted.
    task automatic do_reset();
        @(negedge clock);
        resetn         = 1'b0;
        request0_valid = 1'b1; request0_write = 1'b0;
        request1_valid = 1'b1; request1_write = 1'b0;
        model_reset();
        #1;
        check("reset_ready0", 32'(request0_ready), 32'd0);
        check("reset_ready1", 32'(request1_ready), 32'd0);
        check_responses();
        @(posedge clock);
        @(negedge clock);
        request0_valid = 1'b0;
        request1_valid = 1'b0;
        resetn         = 1'b1;
    endtask

    // One clock cycle of stimulus with model update at the rising edge.
    task automatic cycle(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                         input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
        int fav;
        bit g0, g1;
        @(negedge clock);
        request0_valid = v0; request0_write = w0; request0_address = a0; request0_write_data = d0;
        request1_valid = v1; request1_write = w1; request1_address = a1; request1_write_data = d1;
        #1;
        check_responses();
        fav = ROUND_ROBIN ? model_favoured : 0;
        g0  = v0 && (!v1 || fav == 0);
        g1  = v1 && !g0;
        check("ready0", 32'(request0_ready), 32'(g0));
        check("ready1", 32'(request1_ready), 32'(g1));
        @(posedge clock);
        exp_valid[0] = 1'b0;
        exp_valid[1] = 1'b0;
        if (g0) begin
            if (w0) model_mem[a0] = d0;
            else begin exp_valid[0] = 1'b1; exp_data[0] = model_mem[a0]; end
            model_favoured = 1;
        end else if (g1) begin
            if (w1) model_mem[a1] = d1;
            else begin exp_valid[1] = 1'b1; exp_data[1] = model_mem[a1]; end
            model_favoured = 0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Never-written address reads as zero
        cycle(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        idle();

        // Write then immediate read-back by requester 0
        cycle(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        idle();

        // Lone requester 1 write to the top address, read back by both sides
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd15, 8'h3C);
        idle();
        cycle(1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd15, 8'h00);
        idle();

        // Contention from a fresh pointer: both read addresses 1 and 2
        do_reset();
        cycle(1'b1, 1'b1, 4'd1, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
        end
        idle();

        // Reset pulse right after a read is accepted cancels the response
        cycle(1'b1, 1'b1, 4'd9, 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00);
        cycle(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        #1 resetn = 1'b0;
        model_reset();
        #1;
        check("pulse_resp0_valid", 32'(response0_valid), 32'd0);
        check("pulse_resp0_data",  32'(response0_data),  32'd0);
        #1 resetn = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b1, 1'b0, AW'(a), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        end
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
        end
        idle();

        // Full read-back of memory contents
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, AW'(a), 8'h00);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
